// File: rtl/mag_cmp_stream.sv
// Streaming magnitude comparator. Two WIDTH*BEATS-bit operands arrive one beat
// at a time, MSB beat first. The result is eq/lt/gt (optionally signed) plus the
// index of the first differing beat. Valid/ready handshakes on both sides.
module mag_cmp_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BEATS = 4,
    localparam int unsigned BW = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_eq,
    output logic             res_lt,
    output logic             res_gt,
    output logic [BW-1:0]    res_beat
);

    typedef enum logic [0:0] {StCollect, StResult} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          dec_lt_q, dec_lt_d;
    logic          dec_gt_q, dec_gt_d;
    logic [BW-1:0] dec_beat_q, dec_beat_d;
    logic          res_eq_q, res_eq_d;
    logic          res_lt_q, res_lt_d;
    logic          res_gt_q, res_gt_d;
    logic [BW-1:0] res_beat_q, res_beat_d;

    logic beat_ne;
    logic beat_lt;
    logic last_beat;
    logic decided;

    // Per-beat compare; in_signed only matters on the MSB beat, where the sign lives.
    always_comb begin
        beat_ne   = (in_a != in_b);
        beat_lt   = (cnt_q == '0 && in_signed) ? ($signed(in_a) < $signed(in_b))
                                               : (in_a < in_b);
        last_beat = (cnt_q == BW'(BEATS - 1));
        decided   = dec_lt_q || dec_gt_q;
    end

    // Next-state: beat counting, first-difference capture, result registration.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dec_lt_d   = dec_lt_q;
        dec_gt_d   = dec_gt_q;
        dec_beat_d = dec_beat_q;
        res_eq_d   = res_eq_q;
        res_lt_d   = res_lt_q;
        res_gt_d   = res_gt_q;
        res_beat_d = res_beat_q;
        unique case (state_q)
            StCollect: begin
                if (in_valid) begin
                    // Once decided, remaining beats are consumed without effect.
                    if (!decided && beat_ne) begin
                        dec_lt_d   = beat_lt;
                        dec_gt_d   = !beat_lt;
                        dec_beat_d = cnt_q;
                    end
                    if (last_beat) begin
                        res_lt_d   = dec_lt_d;
                        res_gt_d   = dec_gt_d;
                        res_eq_d   = !(dec_lt_d || dec_gt_d);
                        res_beat_d = dec_beat_d;
                        state_d    = StResult;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d    = StCollect;
                    dec_lt_d   = 1'b0;
                    dec_gt_d   = 1'b0;
                    dec_beat_d = '0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State and result registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StCollect;
            cnt_q      <= '0;
            dec_lt_q   <= 1'b0;
            dec_gt_q   <= 1'b0;
            dec_beat_q <= '0;
            res_eq_q   <= 1'b0;
            res_lt_q   <= 1'b0;
            res_gt_q   <= 1'b0;
            res_beat_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dec_lt_q   <= dec_lt_d;
            dec_gt_q   <= dec_gt_d;
            dec_beat_q <= dec_beat_d;
            res_eq_q   <= res_eq_d;
            res_lt_q   <= res_lt_d;
            res_gt_q   <= res_gt_d;
            res_beat_q <= res_beat_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        in_ready  = (state_q == StCollect);
        res_valid = (state_q == StResult);
        res_eq    = res_eq_q;
        res_lt    = res_lt_q;
        res_gt    = res_gt_q;
        res_beat  = res_beat_q;
    end

endmodule

// File: tb/tb_mag_cmp_stream.sv
// Directed bench for mag_cmp_stream with default parameters (WIDTH=8, BEATS=4).
module tb_mag_cmp_stream;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_signed;
    logic       res_valid;
    logic       res_ready;
    logic       res_eq;
    logic       res_lt;
    logic       res_gt;
    logic [1:0] res_beat;

    int n_checks = 0;
    int n_fails  = 0;

    mag_cmp_stream #(
        .WIDTH(8),
        .BEATS(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_signed(in_signed),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_eq   (res_eq),
        .res_lt   (res_lt),
        .res_gt   (res_gt),
        .res_beat (res_beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame MSB beat first; sgn gives in_signed per beat (bit 3 = beat 0).
    task automatic send_frame(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] sgn, input int gap_after1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check({tag, ".no_early_valid"}, 32'(res_valid), 32'h0);
            in_valid  = 1'b1;
            in_a      = a[31-8*i -: 8];
            in_b      = b[31-8*i -: 8];
            in_signed = sgn[3-i];
            tick();
            if (i == 1) begin
                for (int g = 0; g < gap_after1; g++) begin
                    in_valid  = 1'b0;
                    in_a      = 8'h5A;
                    in_b      = 8'hA5;
                    in_signed = ~in_signed;
                    tick();
                end
            end
        end
        in_valid  = 1'b0;
        in_signed = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic eq, input logic lt, input logic gt,
                             input logic [1:0] beat);
        check({tag, ".res_valid"}, 32'(res_valid), 32'h1);
        check({tag, ".in_ready"},  32'(in_ready),  32'h0);
        check({tag, ".res_eq"},    32'(res_eq),    32'(eq));
        check({tag, ".res_lt"},    32'(res_lt),    32'(lt));
        check({tag, ".res_gt"},    32'(res_gt),    32'(gt));
        check({tag, ".res_beat"},  32'(res_beat),  32'(beat));
    endtask

    task automatic take_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, ".in_ready_after"},  32'(in_ready),  32'h1);
        check({tag, ".res_valid_after"}, 32'(res_valid), 32'h0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_signed = 1'b0;
        res_ready = 1'b0;
        #12;
        check("rst.in_ready",  32'(in_ready),  32'h1);
        check("rst.res_valid", 32'(res_valid), 32'h0);
        check("rst.res_eq",    32'(res_eq),    32'h0);
        check("rst.res_lt",    32'(res_lt),    32'h0);
        check("rst.res_gt",    32'(res_gt),    32'h0);
        check("rst.res_beat",  32'(res_beat),  32'h0);
        reset_n = 1'b1;
        tick();

        // 1. Equal operands
        send_frame("eq", 32'h12345678, 32'h12345678, 4'b0000, 0);
        check_res("eq", 1'b1, 1'b0, 1'b0, 2'd0);
        take_result("eq");

        // 2. Late differences
        send_frame("late_gt", 32'h00000500, 32'h00000400, 4'b0000, 0);
        check_res("late_gt", 1'b0, 1'b0, 1'b1, 2'd2);
        take_result("late_gt");
        send_frame("late_lt", 32'h000000FE, 32'h000000FF, 4'b0000, 0);
        check_res("late_lt", 1'b0, 1'b1, 1'b0, 2'd3);
        take_result("late_lt");

        // 3. Signed mode on the MSB beat, in_signed ignored on later beats
        send_frame("sgn1", 32'h80000000, 32'h7F000000, 4'b1000, 0);
        check_res("sgn1", 1'b0, 1'b1, 1'b0, 2'd0);
        take_result("sgn1");
        send_frame("sgn0", 32'h80000000, 32'h7F000000, 4'b0000, 0);
        check_res("sgn0", 1'b0, 1'b0, 1'b1, 2'd0);
        take_result("sgn0");
        send_frame("sgn1_tog", 32'h80000000, 32'h7F000000, 4'b1111, 0);
        check_res("sgn1_tog", 1'b0, 1'b1, 1'b0, 2'd0);
        take_result("sgn1_tog");
        send_frame("sgn0_tog", 32'h80000000, 32'h7F000000, 4'b0101, 0);
        check_res("sgn0_tog", 1'b0, 1'b0, 1'b1, 2'd0);
        take_result("sgn0_tog");

        // 4. Decision locking
        send_frame("lock", 32'h01FF0000, 32'h00000000, 4'b0000, 0);
        check_res("lock", 1'b0, 1'b0, 1'b1, 2'd0);
        take_result("lock");

        // 5. Idle gap mid-frame, then backpressure with ignored in_valid pulses
        send_frame("gap", 32'h00000500, 32'h00000400, 4'b0000, 3);
        check_res("gap", 1'b0, 1'b0, 1'b1, 2'd2);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_a     = 8'h00;
            in_b     = 8'hFF;
            tick();
            check_res("bp", 1'b0, 1'b0, 1'b1, 2'd2);
        end
        in_valid = 1'b0;
        take_result("bp");
        // Pulses during backpressure must not have been consumed as beats.
        send_frame("post_bp", 32'h000000FE, 32'h000000FF, 4'b0000, 0);
        check_res("post_bp", 1'b0, 1'b1, 1'b0, 2'd3);
        take_result("post_bp");

        // 6. Reset mid-frame
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a     = 8'hFF;
            in_b     = 8'h00;
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("mrst.in_ready",  32'(in_ready),  32'h1);
        check("mrst.res_valid", 32'(res_valid), 32'h0);
        check("mrst.res_eq",    32'(res_eq),    32'h0);
        check("mrst.res_lt",    32'(res_lt),    32'h0);
        check("mrst.res_gt",    32'(res_gt),    32'h0);
        check("mrst.res_beat",  32'(res_beat),  32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        send_frame("after_rst", 32'h000000AA, 32'h000000AA, 4'b0000, 0);
        check_res("after_rst", 1'b1, 1'b0, 1'b0, 2'd0);
        take_result("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
